// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// A multiply holds its operands for MUL_LAT cycles while one 64-bit product
// settles. A divide runs a 32-step radix-2 restoring loop and then a fix-up
// cycle that restores signs.
// The block owns the architectural HI/LO registers and applies mthi/mtlo.
//
// state | meaning
// IDLE  | waiting; accepts start or mthi/mtlo
// MUL   | product settling; the latency counter runs down to zero
// DIV   | one restoring-divide step per cycle, 32 steps in total
// FIX   | sign correction and divide-by-zero result, then HI/LO written
module md_ctrl #(
    parameter int MUL_LAT  = 3,   // 1..15
    parameter int DIV_ITER = 32   // fixed; the datapath is 32 bits wide
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic [1:0]  mdOp,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        hiWe,
    input  logic        loWe,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        op_sx;        // signed flavour (mult/div)
    logic [31:0] op_a, op_b;   // raw latched din1/din2
    logic [31:0] rem, quo, dvsr;
    logic        q_neg, r_neg;

    logic        accept, wr_ok;
    logic [31:0] abs1, abs2;
    logic [63:0] prod;
    logic [32:0] rem_sh, trial;
    logic [31:0] q_fix, r_fix;

    assign accept = (state == IDLE) && start && !flush;
    assign wr_ok  = (state == IDLE) && !start && !flush;

    assign abs1 = din1[31] ? (~din1 + 32'd1) : din1;
    assign abs2 = din2[31] ? (~din2 + 32'd1) : din2;

    // Operands are sign- or zero-extended to 64 bits so one multiplier serves both flavours.
    assign prod = {{32{op_sx & op_a[31]}}, op_a} * {{32{op_sx & op_b[31]}}, op_b};

    // One restoring step. The remainder is always below the divisor, so a 33-bit trial is enough.
    assign rem_sh = {rem, quo[31]};
    assign trial  = rem_sh - {1'b0, dvsr};

    assign q_fix = q_neg ? (~quo + 32'd1) : quo;
    assign r_fix = r_neg ? (~rem + 32'd1) : rem;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = mdOp[1] ? MUL : DIV;
            MUL:  if (flush || cnt == 5'd0) state_nx = IDLE;
            DIV:  if (flush) state_nx = IDLE;
                  else if (cnt == 5'd0) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, counter, HI/LO and the registered busy/done flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            op_sx <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_sx <= ~mdOp[0];
                        op_a  <= din1;
                        op_b  <= din2;
                        cnt   <= mdOp[1] ? 5'(MUL_LAT - 1) : 5'(DIV_ITER - 1);
                        rem   <= '0;
                        quo   <= mdOp[0] ? din1 : abs1;
                        dvsr  <= mdOp[0] ? din2 : abs2;
                        q_neg <= ~mdOp[0] & (din1[31] ^ din2[31]);
                        r_neg <= ~mdOp[0] & din1[31];
                    end else if (wr_ok) begin
                        if (hiWe) hi <= wdata;
                        if (loWe) lo <= wdata;
                    end
                end
                MUL: begin
                    if (!flush) begin
                        if (cnt == 5'd0) begin
                            hi   <= prod[63:32];
                            lo   <= prod[31:0];
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                DIV: begin
                    if (!flush) begin
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        if (cnt != 5'd0) cnt <= cnt - 5'd1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        // A zero divisor returns the dividend in HI and all-ones in LO.
                        if (op_b == 32'd0) begin
                            hi <= op_a;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl. Directed cases pin the result values with literals.
// A reference model computes results with plain integer arithmetic and
// counts cycles to completion; the DUT outputs are compared with it every cycle.
module tb_md_ctrl;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [1:0]  mdOp;
    logic [31:0] din1, din2;
    logic        hiWe, loWe;
    logic [31:0] wdata;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rstN(rstN), .start(start), .mdOp(mdOp),
        .din1(din1), .din2(din2), .hiWe(hiWe), .loWe(loWe),
        .wdata(wdata), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one md operation: {hi, lo}.
    function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sp, sq, sr;
        longint unsigned up;
        logic [63:0]     r;
        if (op[1]) begin
            if (!op[0]) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = sp;
            end else begin
                up = longint'(a) * longint'(b);
                r  = up;
            end
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (!op[0]) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            r  = {sr[31:0], sq[31:0]};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    // Reference model: an operation finishes MUL_LAT (multiply) or 33 (divide) edges after acceptance.
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (!flush) begin
                    if (start) begin
                        m_busy        <= 1'b1;
                        {p_hi, p_lo}  <= model_result(mdOp, din1, din2);
                        m_left        <= mdOp[1] ? MUL_LAT : 33;
                    end else begin
                        if (hiWe) m_hi <= wdata;
                        if (loWe) m_lo <= wdata;
                    end
                end
            end else if (flush) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= p_hi;
                m_lo   <= p_lo;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) c++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input int e_busy);
        int nb;
        bit got;
        start = 1'b1; mdOp = op; din1 = a; din2 = b;
        cyc();
        start = 1'b0;
        wait_done(nb, got);
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_hi"}, hi, e_hi);
        chk({name, "_lo"}, lo, e_lo);
        chk({name, "_busy_cycles"}, 32'(nb), 32'(e_busy));
    endtask

    task automatic write_hilo(input logic [31:0] v);
        hiWe = 1'b1; loWe = 1'b1; wdata = v;
        cyc();
        hiWe = 1'b0; loWe = 1'b0;
    endtask

    initial begin
        int nb, c;
        bit got;
        rstN = 1'b0; start = 1'b0; mdOp = 2'b00; din1 = '0; din2 = '0;
        hiWe = 1'b0; loWe = 1'b0; wdata = '0; flush = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        cyc();
        rstN = 1'b1;
        cyc();

        run_op("mult_neg", 2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3);
        run_op("multu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3);
        run_op("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("divu_zero", 2'b01, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 33);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // mthi and mtlo together
        write_hilo(32'h5A5A_0001);
        @(negedge clk);
        chk("mthilo_hi", hi, 32'h5A5A_0001);
        chk("mthilo_lo", lo, 32'h5A5A_0001);

        // start and hiWe in the same idle cycle: start wins
        cyc();
        start = 1'b1; mdOp = 2'b10; din1 = 32'd5; din2 = 32'd6; hiWe = 1'b1; wdata = 32'hAA;
        cyc();
        start = 1'b0; hiWe = 1'b0;
        @(negedge clk);
        chk("start_vs_we_hi", hi, 32'h5A5A_0001);
        chk("start_vs_we_busy", 32'(busy), 32'd1);
        wait_done(nb, got);
        chk("start_vs_we_done", 32'(got), 32'd1);
        chk("start_vs_we_lo", lo, 32'd30);
        chk("start_vs_we_hi_res", hi, 32'd0);

        // hiWe and start while busy are ignored
        cyc();
        write_hilo(32'h5A5A_0002);
        start = 1'b1; mdOp = 2'b01; din1 = 32'd9; din2 = 32'd2;
        cyc();
        start = 1'b0; hiWe = 1'b1; wdata = 32'hAA;
        cyc();
        hiWe = 1'b0;
        @(negedge clk);
        chk("busy_we_hi", hi, 32'h5A5A_0002);
        #1;
        start = 1'b1; mdOp = 2'b10; din1 = 32'd3; din2 = 32'd3;
        cyc();
        start = 1'b0;
        wait_done(nb, got);
        chk("busy_start_done", 32'(got), 32'd1);
        chk("busy_start_lo", lo, 32'd4);
        chk("busy_start_hi", hi, 32'd1);
        count_done(40, c);
        chk("busy_start_no_2nd_done", 32'(c), 32'd0);

        // flush at cycle 10 of a divide
        cyc();
        write_hilo(32'h5A5A_0003);
        start = 1'b1; mdOp = 2'b00; din1 = 32'd1000; din2 = 32'd3;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi, 32'h5A5A_0003);
        chk("flush_lo", lo, 32'h5A5A_0003);
        count_done(40, c);
        chk("flush_no_done", 32'(c), 32'd0);

        // asynchronous reset mid-multiply
        cyc();
        write_hilo(32'h5A5A_0004);
        start = 1'b1; mdOp = 2'b10; din1 = 32'd7; din2 = 32'd7;
        cyc();
        start = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        cyc();
        cyc();
        rstN = 1'b1;
        cyc();

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            mdOp  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: din1 = 32'h8000_0000;
                1: din1 = 32'hFFFF_FFFF;
                default: din1 = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: din2 = 32'd0;
                1: din2 = 32'hFFFF_FFFF;
                2: din2 = 32'($urandom_range(1, 20));
                default: din2 = $urandom;
            endcase
            hiWe  = ($urandom_range(0, 5) == 0);
            loWe  = ($urandom_range(0, 5) == 0);
            wdata = $urandom;
            flush = ($urandom_range(0, 40) == 0);
            cyc();
        end
        start = 1'b0; hiWe = 1'b0; loWe = 1'b0; flush = 1'b0;
        repeat (40) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle HI/LO multiply/divide controller for the EX stage of the MIPS core.
- Accepts one mult/multu/div/divu request from the pipeline and sequences it:
  - multiply: a product computed once and delayed through a latency counter;
  - divide: an iterative radix-2 restoring divider.
- Owns the architectural HI/LO registers and applies mthi/mtlo writes.
- Raises busy so the hazard unit stalls mfhi/mflo and further md operations.

Parameters:
- MUL_LAT, 3, cycles spent in MUL state; legal range 1..15.
- DIV_ITER, 32, restoring-divide iterations; fixed at 32, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- mdOp  in  2  00 div, 01 divu, 10 mult, 11 multu
- din1  in  32  rs operand (dividend / multiplicand)
- din2  in  32  rt operand (divisor / multiplier)
- hiWe  in  1  mthi write enable
- loWe  in  1  mtlo write enable
- wdata  in  32  mthi/mtlo data
- flush  in  1  abort in-flight operation (exception/branch squash)
- busy  out  1  operation in flight; registered
- done  out  1  one-cycle pulse: hi/lo now hold the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rstN).
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal operand/remainder/quotient registers=0.
- Reset mid-operation: abandons the operation immediately; outputs take their reset values.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 sampled at edge T:
  - latch mdOp, din1, din2;
  - mult/multu -> MUL, counter=MUL_LAT-1;
  - div/divu -> DIV, counter=31;
  - busy=1 from cycle T+1.
- MUL:
  - full 64-bit product computed once on entry (signed for mult, unsigned for multu), then held;
  - counter decrements each cycle;
  - on the cycle counter==0: hi=prod[63:32], lo=prod[31:0], go IDLE, busy=0, done=1.
  - Result visible at T+MUL_LAT+1.
- DIV, on entry:
  - signed op: work on |din1|, |din2| and record sign(quotient)=sign1^sign2, sign(remainder)=sign1;
  - divu: raw operands.
- DIV, each cycle:
  - shift {rem, quo} left 1;
  - trial-subtract divisor; if non-negative, keep the difference and set quo[0]=1.
  - After 32 cycles -> FIX.
- FIX:
  - apply sign corrections;
  - hi=remainder, lo=quotient, go IDLE, busy=0, done=1.
  - Result visible at T+34; busy high T+1..T+33.
- Divide by zero (din2==0), both div and divu:
  - runs the full 34 cycles, no early exit;
  - hi=din1 as latched, lo=32'hFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (abs of 0x80000000 treated as unsigned 2^31).
- Widths:
  - |x| computed in 32-bit unsigned;
  - remainder datapath 33 bits for the trial subtract;
  - no truncation except at final HI/LO assignment.
- Arbitration:
  - start while busy=1: ignored.
  - hiWe/loWe while busy=1: ignored; the pipeline must stall mthi/mtlo.
  - In IDLE, start and hiWe/loWe in the same cycle: start wins, the write is dropped.
  - hiWe and loWe together in IDLE: both written with wdata.
- flush:
  - in MUL/DIV/FIX: return to IDLE next edge, busy=0, done=0, hi/lo unchanged;
  - in IDLE: suppresses start and hiWe/loWe in that cycle.
- done is 0 in every cycle except the single completion cycle.
- hi and lo change only:
  - at completion;
  - on an accepted mthi/mtlo;
  - on reset.

Test Plan:
- Reset, then mult with din1=0xFFFFFFFE (-2), din2=3 -> busy high for 3 cycles; then done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with din1=0xFFFFFFFF, din2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T+4.
- div with din1=-7 (0xFFFFFFF9), din2=2 -> busy T+1..T+33; at T+34 lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done=1. Repeat as divu 100/7 -> lo=14, hi=2.
- Boundary divides:
  - divu din2=0, din1=0x1234 -> hi=0x1234, lo=0xFFFFFFFF;
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Collisions:
  - start and hiWe (wdata=0xAA) in the same idle cycle -> the multiply proceeds and the write is lost;
  - hiWe pulsed while busy -> hi unchanged;
  - start pulsed while busy -> no second done.
- Aborts:
  - flush at cycle 10 of a divide -> busy=0 next cycle, hi/lo keep their prior values, no done;
  - rstN low mid-multiply -> hi=lo=0, busy=0 immediately (asynchronously).
